// File: rtl/mem_sync.sv
// rtl/mem_sync.sv - synchronous byte-addressed scratch memory with request/response handshakes
//
// Purpose:
//   Clocked, parametrised scratch RAM for the core load/store/fetch path.
//   Only one request can be outstanding at a time. The response is
//   presented LATENCY cycles after the request is accepted and is held
//   until the response handshake completes.
//
// Optional feature macro:
//   MEM_ALIGN_CHECK_EN - when defined, a request whose unit index is not a
//   multiple of its access size is rejected with rsp_err_o=1 and no write.
//
// Ports:
//   clk          clock, rising edge
//   reset_i      asynchronous reset, active-high
//   req_valid_i  request valid
//   req_ready_o  request ready (high only in IDLE and out of reset)
//   req_addr_i   unit address; only the low $clog2(MEM_SIZE) bits are used
//   req_write_i  1 = write, 0 = read
//   req_size_i   log2 of units accessed (0..3)
//   req_data_i   write data, lane k = bits [(k+1)*WORDSIZE-1 : k*WORDSIZE]
//   rsp_valid_o  response valid
//   rsp_ready_i  response ready
//   rsp_data_o   read data; 0 for writes and errored requests
//   rsp_err_o    response error flag
module mem_sync #(
  parameter int BITSIZE  = 32,
  parameter int WORDSIZE = 8,
  parameter int MEM_SIZE = 1024,
  parameter int LATENCY  = 1
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [31:0]         req_addr_i,
  input  logic                req_write_i,
  input  logic [1:0]          req_size_i,
  input  logic [BITSIZE-1:0]  req_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [BITSIZE-1:0]  rsp_data_o,
  output logic                rsp_err_o
);

  localparam int LANES = BITSIZE / WORDSIZE;
  localparam int AW    = $clog2(MEM_SIZE);
  localparam int CW    = 4;  // holds LATENCY-1 for LATENCY up to 8

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITSIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [WORDSIZE-1:0] mem [MEM_SIZE];

  logic [AW-1:0]       idx;
  logic [AW-1:0]       base;
  logic [3:0]          units;
  logic                size_err;
  logic                align_err;
  logic                req_err;
  logic                accept;
  logic                wr_en;
  logic [LANES-1:0]    lane_en;
  logic [BITSIZE-1:0]  line;
  logic                unused_addr_bits;

  assign idx   = req_addr_i[AW-1:0];
  assign base  = idx & ~AW'(LANES - 1);
  assign units = 4'd1 << req_size_i;

  // Upper address bits are ignored; the address space wraps modulo MEM_SIZE.
  assign unused_addr_bits = ^req_addr_i[31:AW];

  assign size_err = int'(units) > LANES;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = |(idx & AW'(units - 4'd1));
`else
  assign align_err = 1'b0;
`endif

  assign req_err = size_err | align_err;
  assign accept  = req_valid_i & req_ready_o;
  assign wr_en   = accept & req_write_i & ~req_err;

  always_comb begin
    lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_en[k] = (k < int'(units));
    end
  end

  // Full aligned line around idx; read regardless of access size.
  always_comb begin
    line = '0;
    for (int k = 0; k < LANES; k++) begin
      line[k*WORDSIZE +: WORDSIZE] = mem[base + AW'(k)];
    end
  end

  // Array is deliberately not reset so contents survive reset_i.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) begin
          mem[idx + AW'(k)] <= req_data_i[k*WORDSIZE +: WORDSIZE];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = ~reset_i;
        if (req_valid_i && !reset_i) begin
          rsp_err_d  = req_err;
          rsp_data_d = (req_write_i || req_err) ? '0 : line;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // The counter hits 0 on the same edge that enters RESP, so the
        // response is visible LATENCY-1 edges after accept and is first
        // sampled by the consumer LATENCY edges after accept.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_mem_sync.sv
// tb/tb_mem_sync.sv - scoreboard testbench for mem_sync with a byte-array reference model
module tb_mem_sync;

  localparam int LAT   = 4;
  localparam int MSIZE = 1024;
  localparam int LN    = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  mem_sync #(
    .BITSIZE (32),
    .WORDSIZE(8),
    .MEM_SIZE(MSIZE),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_size_i (req_size_i),
    .req_data_i (req_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_err_o  (rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_edge;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mm [MSIZE];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ready_mode = 1;  // 0 hold low, 1 hold high, 2 random
  logic       prev_valid = 1'b0;
  logic       was_reset = 1'b0;
  logic       post_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as a flat array of units, index arithmetic mod MSIZE.
  function automatic exp_t model(input logic w, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx, units, base;
    idx   = int'(addr) & (MSIZE - 1);
    units = 1 << sz;
    e.err = (units > LN);
`ifdef MEM_ALIGN_CHECK_EN
    if ((idx % units) != 0) e.err = 1'b1;
`endif
    e.data = 32'h0;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < units; k++) mm[(idx + k) % MSIZE] = data[k*8 +: 8];
      end else begin
        base = idx - (idx % LN);
        for (int k = 0; k < LN; k++) e.data[k*8 +: 8] = mm[(base + k) % MSIZE];
      end
    end
    e.acc_edge = 0;
    return e;
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   waited;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_size_i  = sz;
    req_addr_i  = addr;
    req_data_i  = data;
    waited = 0;
    @(negedge clk);
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready_o stayed 0 for %0d cycles, expected 1", waited);
      req_valid_i = 1'b0;
      return;
    end
    e = model(w, sz, addr, data);
    e.acc_edge = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Response ready driver
  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rsp_ready_i = 1'b0;
        1:       rsp_ready_i = 1'b1;
        default: rsp_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (reset_i) begin
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_req_ready", 32'(req_ready_o), 32'h0);
      chk("rst_rsp_data", rsp_data_o, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
      prev_valid = 1'b0;
      was_reset  = 1'b1;
      post_hs    = 1'b0;
    end else begin
      if (was_reset) chk("ready_after_reset", 32'(req_ready_o), 32'h1);
      was_reset = 1'b0;
      if (post_hs) chk("ready_after_hs", 32'(req_ready_o), 32'h1);
      post_hs = 1'b0;
      if (rsp_valid_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_rsp: rsp_valid_o=1 with no request outstanding, expected 0");
        end else begin
          if (!prev_valid) chk("latency", 32'(cyc + 1 - q[0].acc_edge), 32'(LAT));
          chk("rsp_data", rsp_data_o, q[0].data);
          chk("rsp_err", 32'(rsp_err_o), 32'(q[0].err));
          chk("busy_ready", 32'(req_ready_o), 32'h0);
          if (rsp_ready_i) begin
            void'(q.pop_front());
            post_hs = 1'b1;
          end
        end
      end
      prev_valid = rsp_valid_o;
    end
  end

  initial begin
    int waited;
    reset_i     = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_size_i  = '0;
    req_data_i  = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Fill the whole memory so every later read has a defined model value.
    for (int a = 0; a < MSIZE; a += 4) issue(1'b1, 2'd2, 32'(a), $urandom);
    drain();

    // Basic word write then read-back
    issue(1'b1, 2'd2, 32'h10, 32'h7c7fe2b7);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    // Byte and halfword merges into an existing line
    issue(1'b1, 2'd2, 32'h10, 32'h11223344);
    issue(1'b1, 2'd0, 32'h13, 32'h000000AA);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    issue(1'b1, 2'd1, 32'h10, 32'h0000BEEF);
    issue(1'b0, 2'd0, 32'h12, 32'h0);
    // Unsupported size: error, no write
    issue(1'b1, 2'd3, 32'h20, 32'hDEADBEEF);
    issue(1'b0, 2'd3, 32'h20, 32'h0);
    issue(1'b0, 2'd2, 32'h20, 32'h0);
    // Wrap past the top of memory
    issue(1'b1, 2'd2, 32'(MSIZE - 2), 32'hCAFEF00D);
    issue(1'b0, 2'd2, 32'(MSIZE - 4), 32'h0);
    issue(1'b0, 2'd2, 32'h0, 32'h0);
    // Upper address bits ignored
    issue(1'b0, 2'd2, 32'hFFFF_0010, 32'h0);
    drain();

    // Stalled response: ready low for 3 cycles after valid rises
    ready_mode = 0;
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    waited = 0;
    while (!rsp_valid_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("stall_valid_seen", 32'(rsp_valid_o), 32'h1);
    repeat (3) @(negedge clk);
    ready_mode = 1;
    drain();

    // Randomised traffic with random response back-pressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end
    ready_mode = 1;
    drain();

    // Reset during WAIT of a read; memory contents must survive
    issue(1'b1, 2'd2, 32'h40, 32'h5A5AA5A5);
    issue(1'b0, 2'd2, 32'h40, 32'h0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    issue(1'b0, 2'd2, 32'h40, 32'h0);
    issue(1'b0, 2'd1, 32'h12, 32'h0);
    drain();

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
